// File: rtl/color_fx_pkg.sv
// color_fx_pkg: shared colour/state types and helpers for the colour-flash scheduler
package color_fx_pkg;

    localparam int COLOR_W = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} state_t;

    function automatic rgb_t unpack_rgb(input logic [COLOR_W-1:0] c);
        return '{r: c[11:8], g: c[7:4], b: c[3:0]};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending requester at or above the pointer
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          valid_o
);

    logic [PW-1:0] idx;

    // scan downward from the farthest offset so the nearest pending index overwrites last
    always_comb begin
        grant_o = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (pending_i[idx]) begin
                grant_o = '0;
                grant_o[idx] = 1'b1;
            end
        end
    end

    assign valid_o = |pending_i;

endmodule

// File: rtl/color_fx_scheduler.sv
// color_fx_scheduler: round-robin arbitration of colour-flash requests driving a registered 12-bit RGB output
module color_fx_scheduler
    import color_fx_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int PRESCALE_W  = 25,
    parameter int FLASH_PAIRS = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [COLOR_W*NUM_REQ-1:0] req_color_i,
    input  logic [COLOR_W-1:0]         base_color_i,
    input  logic                       idle_blink_i,
    input  logic                       cancel_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic                       busy_o,
    output logic [3:0]                 red_o,
    output logic [3:0]                 green_o,
    output logic [3:0]                 blue_o
);

    localparam int PW = $clog2(NUM_REQ);

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [NUM_REQ-1:0]    pend_q, pend_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [3:0]            phase_q, phase_d;
    logic                  idle_ph_q, idle_ph_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    rgb_t                  col_q, col_d;
    rgb_t                  rgb_q, rgb_d;

    logic                  tick;
    logic [NUM_REQ-1:0]    gnt;
    logic                  gnt_valid;
    logic [PW-1:0]         gidx;
    logic [COLOR_W-1:0]    gcol;

    assign tick = &pre_q;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .pending_i (pend_q),
        .ptr_i     (ptr_q),
        .grant_o   (gnt),
        .valid_o   (gnt_valid)
    );

    // encode the one-hot grant into an index and pick that requester's colour
    always_comb begin
        gidx = '0;
        gcol = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gidx = PW'(i);
                gcol = req_color_i[COLOR_W*i +: COLOR_W];
            end
        end
    end

    // flash state machine; RGB is computed from next-state values so it changes on the same edge as the state
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q + 1'b1;
        pend_d    = pend_q;
        ptr_d     = ptr_q;
        phase_d   = phase_q;
        idle_ph_d = idle_ph_q;
        ack_d     = '0;
        col_d     = col_q;
        case (state_q)
            IDLE: begin
                idle_ph_d = idle_ph_q ^ tick;
                if (gnt_valid) begin
                    state_d = FLASH_ON;
                    col_d   = unpack_rgb(gcol);
                    pend_d  = pend_q & ~gnt;
                    ack_d   = gnt;
                    ptr_d   = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    pre_d   = '0;
                    phase_d = '0;
                end
            end
            FLASH_ON: begin
                if (cancel_i) state_d = IDLE;
                else if (tick) state_d = FLASH_OFF;
            end
            FLASH_OFF: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else if (tick) begin
                    phase_d = phase_q + 4'd1;
                    state_d = (phase_d == 4'(FLASH_PAIRS)) ? IDLE : FLASH_ON;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!idle_blink_i) idle_ph_d = 1'b0;
        pend_d = pend_d | req_i;
        rgb_d = (state_d == FLASH_ON)  ? col_d :
                (state_d == FLASH_OFF) ? rgb_t'('0) :
                unpack_rgb(base_color_i ^ {COLOR_W{idle_ph_d}});
    end

    // state and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            pend_q    <= '0;
            ptr_q     <= '0;
            phase_q   <= '0;
            idle_ph_q <= 1'b0;
            ack_q     <= '0;
            col_q     <= '0;
            rgb_q     <= '0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            phase_q   <= phase_d;
            idle_ph_q <= idle_ph_d;
            ack_q     <= ack_d;
            col_q     <= col_d;
            rgb_q     <= rgb_d;
        end
    end

    assign ack_o   = ack_q;
    assign busy_o  = (state_q != IDLE);
    assign red_o   = rgb_q.r;
    assign green_o = rgb_q.g;
    assign blue_o  = rgb_q.b;

endmodule

// File: tb/tb_color_fx_scheduler.sv
// tb_color_fx_scheduler: directed checks of arbitration, flash timing, blink, cancel and reset
module tb_color_fx_scheduler;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [12*N-1:0] req_color = {12'hABC, 12'hF00, 12'h00F, 12'h0F0};
    logic [11:0]     base_color = 12'h123;
    logic            idle_blink = 1'b0;
    logic            cancel = 1'b0;
    logic [N-1:0]    ack;
    logic            busy;
    logic [3:0]      red, green, blue;
    logic [11:0]     rgb;
    int              checks = 0;
    int              errors = 0;
    int              e = 0;

    assign rgb = {red, green, blue};

    always #5 clk = ~clk;

    color_fx_scheduler #(.NUM_REQ(N), .PRESCALE_W(4), .FLASH_PAIRS(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_i        (req),
        .req_color_i  (req_color),
        .base_color_i (base_color),
        .idle_blink_i (idle_blink),
        .cancel_i     (cancel),
        .ack_o        (ack),
        .busy_o       (busy),
        .red_o        (red),
        .green_o      (green),
        .blue_o       (blue)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [11:0] c, input logic b, input logic [3:0] a);
        chk({tag, "_rgb"}, rgb, c);
        chk({tag, "_busy"}, {11'b0, busy}, {11'b0, b});
        chk({tag, "_ack"}, {8'b0, ack}, {8'b0, a});
    endtask

    task automatic go_to(input int n);
        while (e < n) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    initial begin
        #12;
        expect_out("reset", 12'h000, 1'b0, 4'b0000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        e = 0;
        go_to(1);  expect_out("first_edge", 12'h123, 1'b0, 4'b0000);
        idle_blink = 1'b1;
        go_to(2);  chk("blink_e2", rgb, 12'h123);
        go_to(15); chk("blink_e15", rgb, 12'h123);
        go_to(16); chk("blink_e16", rgb, 12'hEDC);
        go_to(31); chk("blink_e31", rgb, 12'hEDC);
        go_to(32); chk("blink_e32", rgb, 12'h123);
        go_to(48); chk("blink_e48", rgb, 12'hEDC);
        idle_blink = 1'b0;
        go_to(49); chk("blink_clear", rgb, 12'h123);
        req = 4'b0100;
        go_to(50); req = '0;
        expect_out("req2_pend", 12'h123, 1'b0, 4'b0000);
        go_to(51);  expect_out("req2_grant", 12'hF00, 1'b1, 4'b0100);
        go_to(52);  expect_out("req2_on", 12'hF00, 1'b1, 4'b0000);
        go_to(66);  expect_out("req2_on_end", 12'hF00, 1'b1, 4'b0000);
        go_to(67);  expect_out("req2_off", 12'h000, 1'b1, 4'b0000);
        go_to(82);  chk("req2_off_end", rgb, 12'h000);
        go_to(83);  chk("req2_on2", rgb, 12'hF00);
        go_to(99);  chk("req2_off2", rgb, 12'h000);
        go_to(114); expect_out("req2_last", 12'h000, 1'b1, 4'b0000);
        go_to(115); expect_out("req2_done", 12'h123, 1'b0, 4'b0000);

        reset_n = 1'b0;
        #2;
        expect_out("reset2", 12'h000, 1'b0, 4'b0000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        e = 0;
        go_to(1);   req = 4'b1111;
        go_to(2);   req = '0;
        expect_out("all_pend", 12'h123, 1'b0, 4'b0000);
        go_to(3);   expect_out("all_g0", 12'h0F0, 1'b1, 4'b0001);
        go_to(67);  expect_out("all_idle1", 12'h123, 1'b0, 4'b0000);
        go_to(68);  expect_out("all_g1", 12'h00F, 1'b1, 4'b0010);
        go_to(132); expect_out("all_idle2", 12'h123, 1'b0, 4'b0000);
        go_to(133); expect_out("all_g2", 12'hF00, 1'b1, 4'b0100);
        go_to(197); expect_out("all_idle3", 12'h123, 1'b0, 4'b0000);
        go_to(198); expect_out("all_g3", 12'hABC, 1'b1, 4'b1000);
        go_to(200); req = 4'b0011;
        go_to(201); req = '0;
        go_to(262); expect_out("wrap_idle", 12'h123, 1'b0, 4'b0000);
        go_to(263); expect_out("wrap_g0", 12'h0F0, 1'b1, 4'b0001);
        go_to(270); req = 4'b0010;
        go_to(271); req = '0;
        go_to(279); expect_out("mid_off", 12'h000, 1'b1, 4'b0000);
        go_to(295); expect_out("mid_on2", 12'h0F0, 1'b1, 4'b0000);
        go_to(327); expect_out("mid_idle", 12'h123, 1'b0, 4'b0000);
        go_to(328); expect_out("mid_g1", 12'h00F, 1'b1, 4'b0010);
        go_to(392); expect_out("merge_idle", 12'h123, 1'b0, 4'b0000);
        go_to(393); expect_out("merge_none", 12'h123, 1'b0, 4'b0000);

        req = 4'b0100;
        go_to(394); req = '0;
        go_to(395); expect_out("cx_g2", 12'hF00, 1'b1, 4'b0100);
        req = 4'b1000;
        go_to(396); req = '0;
        go_to(399); expect_out("cx_before", 12'hF00, 1'b1, 4'b0000);
        cancel = 1'b1;
        go_to(400); cancel = 1'b0;
        expect_out("cx_idle", 12'h123, 1'b0, 4'b0000);
        go_to(401); expect_out("cx_g3", 12'hABC, 1'b1, 4'b1000);
        go_to(405);
        reset_n = 1'b0;
        #2;
        expect_out("async_rst", 12'h000, 1'b0, 4'b0000);
        @(posedge clk); #1;
        expect_out("rst_hold", 12'h000, 1'b0, 4'b0000);

        reset_n = 1'b1;
        e = 0;
        cancel = 1'b1;
        req = 4'b0001;
        go_to(1); req = '0;
        expect_out("idle_cx_pend", 12'h123, 1'b0, 4'b0000);
        go_to(2); expect_out("idle_cx_grant", 12'h0F0, 1'b1, 4'b0001);
        go_to(3); expect_out("on_cx", 12'h123, 1'b0, 4'b0000);
        cancel = 1'b0;
        go_to(4); expect_out("after_cx", 12'h123, 1'b0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
